// File: rtl/debug_frame_rx.sv
// debug_frame_rx: pops UART bytes, assembles 7-byte XOR-checked dump frames and
// presents good frames on a valid/ready port. Optional inter-byte timeout: DEBUG_FRAME_RX_TIMEOUT_EN.
module debug_frame_rx #(
   parameter int UART_BUS_SIZE  = 8,
   parameter int WORD_SIZE      = 32,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int TIMEOUT_BITS   = 17
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_rx_empty,
   input  logic [UART_BUS_SIZE-1:0] i_rx_data,
   output logic                     o_rx_rd,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic [UART_BUS_SIZE-1:0] o_type,
   output logic [UART_BUS_SIZE-1:0] o_index,
   output logic [WORD_SIZE-1:0]     o_data,
   output logic                     o_crc_error,
   output logic                     o_timeout,
   output logic [15:0]              o_frame_count
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_OUTPUT  = 2'd2
   } state_t;

   function automatic logic [UART_BUS_SIZE-1:0] xor_acc(
      input logic [UART_BUS_SIZE-1:0] acc,
      input logic [UART_BUS_SIZE-1:0] b
   );
      return acc ^ b;
   endfunction

   function automatic logic is_frame_type(input logic [UART_BUS_SIZE-1:0] b);
      return (b >= UART_BUS_SIZE'(1)) && (b <= UART_BUS_SIZE'(4));
   endfunction

   state_t                   state_r, state_nxt_s;
   logic [2:0]               cnt_r, cnt_nxt_s;
   logic [UART_BUS_SIZE-1:0] xor_r, xor_nxt_s;
   logic [UART_BUS_SIZE-1:0] type_acc_r, type_acc_nxt_s;
   logic [UART_BUS_SIZE-1:0] index_acc_r, index_acc_nxt_s;
   logic [WORD_SIZE-1:0]     data_acc_r, data_acc_nxt_s;
   logic [UART_BUS_SIZE-1:0] out_type_r, out_index_r;
   logic [WORD_SIZE-1:0]     out_data_r;
   logic                     valid_r, valid_nxt_s;
   logic                     crc_error_r, crc_error_nxt_s;
   logic                     timeout_r, timeout_nxt_s;
   logic [15:0]              frame_count_r;
   logic                     load_out_s, accept_s, rd_s, timeout_hit_s;

   assign rd_s = ((state_r == ST_IDLE) || (state_r == ST_COLLECT)) && !i_rx_empty && !i_reset;

`ifdef DEBUG_FRAME_RX_TIMEOUT_EN
   localparam logic [TIMEOUT_BITS-1:0] TO_LAST = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);
   logic [TIMEOUT_BITS-1:0] to_cnt_r;

   // Idle-cycle counter: runs only while a frame is open and the FIFO is starved.
   always_ff @(posedge i_clk) begin
      if (i_reset || (state_r != ST_COLLECT) || rd_s) begin
         to_cnt_r <= '0;
      end else if (i_rx_empty) begin
         to_cnt_r <= to_cnt_r + TIMEOUT_BITS'(1);
      end else begin
         to_cnt_r <= to_cnt_r;
      end
   end

   assign timeout_hit_s = (state_r == ST_COLLECT) && i_rx_empty && (to_cnt_r == TO_LAST);
`else
   // Constant-false; the timeout parameters stay referenced in the untimed build.
   assign timeout_hit_s = (TIMEOUT_BITS < 0) && (TIMEOUT_CYCLES < 0);
`endif

   // Next-state and datapath decode for frame assembly and handshake.
   always_comb begin
      state_nxt_s     = state_r;
      cnt_nxt_s       = cnt_r;
      xor_nxt_s       = xor_r;
      type_acc_nxt_s  = type_acc_r;
      index_acc_nxt_s = index_acc_r;
      data_acc_nxt_s  = data_acc_r;
      valid_nxt_s     = valid_r;
      crc_error_nxt_s = 1'b0;
      timeout_nxt_s   = 1'b0;
      load_out_s      = 1'b0;
      accept_s        = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (rd_s && is_frame_type(i_rx_data)) begin
               type_acc_nxt_s = i_rx_data;
               xor_nxt_s      = i_rx_data;
               cnt_nxt_s      = 3'd1;
               state_nxt_s    = ST_COLLECT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_COLLECT: begin
            if (rd_s) begin
               if (cnt_r == 3'd6) begin
                  cnt_nxt_s = 3'd0;
                  xor_nxt_s = '0;
                  if (i_rx_data == xor_r) begin
                     load_out_s  = 1'b1;
                     valid_nxt_s = 1'b1;
                     state_nxt_s = ST_OUTPUT;
                  end else begin
                     crc_error_nxt_s = 1'b1;
                     state_nxt_s     = ST_IDLE;
                  end
               end else begin
                  if (cnt_r == 3'd1) begin
                     index_acc_nxt_s = i_rx_data;
                  end else begin
                     data_acc_nxt_s = {data_acc_r[WORD_SIZE-UART_BUS_SIZE-1:0], i_rx_data};
                  end
                  xor_nxt_s = xor_acc(xor_r, i_rx_data);
                  cnt_nxt_s = cnt_r + 3'd1;
               end
            end else if (timeout_hit_s) begin
               timeout_nxt_s = 1'b1;
               cnt_nxt_s     = 3'd0;
               xor_nxt_s     = '0;
               state_nxt_s   = ST_IDLE;
            end else begin
               state_nxt_s = ST_COLLECT;
            end
         end
         ST_OUTPUT: begin
            if (valid_r && i_ready) begin
               valid_nxt_s = 1'b0;
               accept_s    = 1'b1;
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_OUTPUT;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            valid_nxt_s = 1'b0;
         end
      endcase
   end

   // State, accumulators and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_r       <= ST_IDLE;
         cnt_r         <= 3'd0;
         xor_r         <= '0;
         type_acc_r    <= '0;
         index_acc_r   <= '0;
         data_acc_r    <= '0;
         out_type_r    <= '0;
         out_index_r   <= '0;
         out_data_r    <= '0;
         valid_r       <= 1'b0;
         crc_error_r   <= 1'b0;
         timeout_r     <= 1'b0;
         frame_count_r <= 16'd0;
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         xor_r       <= xor_nxt_s;
         type_acc_r  <= type_acc_nxt_s;
         index_acc_r <= index_acc_nxt_s;
         data_acc_r  <= data_acc_nxt_s;
         valid_r     <= valid_nxt_s;
         crc_error_r <= crc_error_nxt_s;
         timeout_r   <= timeout_nxt_s;
         if (load_out_s) begin
            out_type_r  <= type_acc_r;
            out_index_r <= index_acc_r;
            out_data_r  <= data_acc_r;
         end
         if (accept_s) begin
            frame_count_r <= frame_count_r + 16'd1;
         end
      end
   end

   assign o_rx_rd       = rd_s;
   assign o_valid       = valid_r;
   assign o_type        = out_type_r;
   assign o_index       = out_index_r;
   assign o_data        = out_data_r;
   assign o_crc_error   = crc_error_r;
   assign o_timeout     = timeout_r;
   assign o_frame_count = frame_count_r;

endmodule
